instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL expose the following parameters, one per line as name, default, meaning.
- FIFO_DATA_WIDTH, 8, byte width of rx FIFO read data.
- BUFFER_WORD_SIZE, 16, instruction word width.
- BUFFER_SIZE, 1024, unified buffer depth.
- ADDRESS_SIZE, $clog2(BUFFER_SIZE), address operand width.
REQ-002 The module SHALL have one clock, clk; reset rst SHALL be asynchronous and active-low.
REQ-003 The module SHALL expose the following ports, one per line as name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, async active-low reset.
- fifo_empty, in, 1, rx FIFO empty flag.
- fifo_re, out, 1, rx FIFO read strobe.
- fifo_r_data, in, FIFO_DATA_WIDTH, read data, valid the cycle after fifo_re.
- flush, in, 1, synchronous abort from the controller.
- instr_valid, out, 1, decoded instruction available.
- instr_ready, in, 1, controller accepts the instruction.
- instr_opcode, out, 4, opcode (word[15:12]).
- instr_arg, out, 12, immediate (word[11:0]).
- instr_addr, out, ADDRESS_SIZE, address operand (second word), zero when the opcode has none.
- illegal, out, 1, one-cycle pulse when a word is dropped.
- instr_count, out, 16, accepted-instruction count; wraps.

Function
REQ-004 Opcodes SHALL be: NOP=0x0, LOAD=0x1 (two-word), STORE=0x2 (two-word), COMPUTE=0x3, RELU_CFG=0x4 (arg[0]=relu_en), HALT=0xF; all other values are illegal.
REQ-005 Word assembly SHALL be little-endian: first byte to [7:0], second byte to [15:8].
REQ-006 The FSM SHALL have states FETCH_LO, FETCH_HI, ADDR_LO, ADDR_HI, HOLD; reset state FETCH_LO.
REQ-007 In any fetch state, fifo_re SHALL assert only when fifo_empty=0 and no read is outstanding; at most one read SHALL be outstanding.
REQ-008 The captured byte SHALL advance the state: FETCH_LO->FETCH_HI->(decode)->ADDR_LO->ADDR_HI->HOLD for two-word opcodes.
REQ-009 At decode, single-word opcodes SHALL go to HOLD; illegal opcodes SHALL pulse illegal, drop the word and return to FETCH_LO.
REQ-010 A two-word instruction whose address word has nonzero bits above ADDRESS_SIZE-1 SHALL pulse illegal and return to FETCH_LO.
REQ-011 instr_valid SHALL assert the cycle after the final byte is captured, and outputs SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-012 Transfer SHALL occur when instr_valid and instr_ready are both 1; next cycle: instr_valid=0, state FETCH_LO, instr_count+1; no fifo_re during HOLD or the transfer cycle.
REQ-013 instr_ready while instr_valid=0 SHALL have no effect.
REQ-014 flush SHALL take priority: next cycle state FETCH_LO, instr_valid=0, any outstanding byte discarded, no count increment even if a transfer coincides.
REQ-015 fifo_empty asserting mid-instruction SHALL stall the FSM in its state without a timeout.
REQ-016 instr_count SHALL wrap 0xFFFF->0x0000.

Reset
REQ-017 On rst=0, the module SHALL immediately set: state FETCH_LO, fifo_re=0, instr_valid=0, instr_opcode=0, instr_arg=0, instr_addr=0, illegal=0, instr_count=0, outstanding-read flag cleared.
REQ-018 Reset mid-instruction SHALL discard partial bytes; the first byte read after reset release SHALL be treated as a low byte.

Structure
REQ-019 opcode_e, fetch_state_e and a two-word-opcode predicate function SHALL reside in shared package utpu_pkg, which the controller also uses.
REQ-020 The module SHALL be a single module with no sub-modules; the byte-pair assembler SHALL be inline.

Verification
REQ-021 Byte stream 0x05,0x30 SHALL give instr_opcode=3, instr_arg=0x005, instr_addr=0, with instr_valid held until instr_ready=1; instr_count becomes 1.
REQ-022 Stream 0x00,0x10,0xFF,0x03 SHALL give LOAD with instr_addr=0x3FF; the address word 0x0400 SHALL instead give an illegal pulse and no instr_valid.
REQ-023 Stream 0x00,0x70 SHALL pulse illegal once; the following 0x01,0x40 SHALL yield RELU_CFG with arg=1.
REQ-024 The FIFO going empty after one byte for 10 cycles SHALL keep fifo_re=0 while empty, and the word SHALL complete correctly when the FIFO refills.
REQ-025 flush asserted in ADDR_HI, and separately coincident with a transfer, SHALL give FETCH_LO, instr_valid=0 and an unchanged count.
REQ-026 rst pulsed low between a low byte and its high byte SHALL cause the next two bytes to form a fresh word.

Source files
------------

// File: rtl/utpu_pkg.sv
// Shared definitions for the micro-TPU instruction path: opcode encoding,
// fetch FSM states and small decode helpers used by fetch and controller.
package utpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_COMPUTE  = 4'h3,
        OP_RELU_CFG = 4'h4,
        OP_HALT     = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH_LO,
        FETCH_HI,
        ADDR_LO,
        ADDR_HI,
        HOLD
    } fetch_state_e;

    // Opcodes followed by an address word.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Opcodes the datapath understands; everything else is dropped.
    function automatic logic is_legal_opcode(input logic [3:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_LOAD, OP_STORE, OP_COMPUTE, OP_RELU_CFG, OP_HALT: legal = 1'b1;
            default:                                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: pulls bytes from the rx FIFO, assembles little-endian
// 16-bit words, decodes opcode/immediate/address and offers the result to
// the controller with a valid/ready handshake.
module instr_fetch
    import utpu_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int BUFFER_SIZE      = 1024,
    parameter int ADDRESS_SIZE     = $clog2(BUFFER_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_re,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_r_data,
    input  logic                       flush,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [3:0]                 instr_opcode,
    output logic [11:0]                instr_arg,
    output logic [ADDRESS_SIZE-1:0]    instr_addr,
    output logic                       illegal,
    output logic [15:0]                instr_count
);

    fetch_state_e                state_q, state_d;
    logic                        rd_pending_q, rd_pending_d;
    logic                        fifo_re_d;
    logic [FIFO_DATA_WIDTH-1:0]  lo_byte_q, lo_byte_d;
    logic [FIFO_DATA_WIDTH-1:0]  addr_lo_q, addr_lo_d;
    logic [3:0]                  opcode_d;
    logic [11:0]                 arg_d;
    logic [ADDRESS_SIZE-1:0]     addr_d;
    logic                        valid_d;
    logic                        illegal_d;
    logic [15:0]                 count_d;

    // Byte-pair assembly: the byte arriving now is always the high half.
    logic [BUFFER_WORD_SIZE-1:0] instr_word;
    logic [BUFFER_WORD_SIZE-1:0] addr_word;
    logic                        capture;

    assign instr_word = {fifo_r_data, lo_byte_q};
    assign addr_word  = {fifo_r_data, addr_lo_q};
    // Data from a read issued last cycle is on fifo_r_data now.
    assign capture    = rd_pending_q;

    // Next-state, datapath and FIFO read-strobe decisions.
    always_comb begin
        // NOTE: every value written here gets a default first so the block
        // stays purely combinational; a missed branch would otherwise infer a latch.
        state_d      = state_q;
        rd_pending_d = fifo_re;
        lo_byte_d    = lo_byte_q;
        addr_lo_d    = addr_lo_q;
        opcode_d     = instr_opcode;
        arg_d        = instr_arg;
        addr_d       = instr_addr;
        valid_d      = instr_valid;
        illegal_d    = 1'b0;
        count_d      = instr_count;
        fifo_re_d    = 1'b0;

        if (flush) begin
            // Abort wins over everything, including a coincident transfer;
            // a byte already requested is dropped on arrival.
            state_d      = FETCH_LO;
            valid_d      = 1'b0;
            rd_pending_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_LO: begin
                    if (capture) begin
                        lo_byte_d = fifo_r_data;
                        state_d   = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (capture) begin
                        if (!is_legal_opcode(instr_word[15:12])) begin
                            illegal_d = 1'b1;
                            state_d   = FETCH_LO;
                        end else begin
                            opcode_d = instr_word[15:12];
                            arg_d    = instr_word[11:0];
                            if (is_two_word(instr_word[15:12])) begin
                                state_d = ADDR_LO;
                            end else begin
                                addr_d  = '0;
                                valid_d = 1'b1;
                                state_d = HOLD;
                            end
                        end
                    end
                end
                ADDR_LO: begin
                    if (capture) begin
                        addr_lo_d = fifo_r_data;
                        state_d   = ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (capture) begin
                        // Address must fit inside the unified buffer.
                        if ((addr_word >> ADDRESS_SIZE) != '0) begin
                            illegal_d = 1'b1;
                            state_d   = FETCH_LO;
                        end else begin
                            addr_d  = addr_word[ADDRESS_SIZE-1:0];
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        count_d = instr_count + 16'd1;
                        state_d = FETCH_LO;
                    end
                end
                default: state_d = FETCH_LO;
            endcase

            // Registered strobe: only one read in flight, and none while the
            // word is held or being handed over. A read landing this cycle is
            // consumed at this edge, so the next one may be issued alongside it.
            fifo_re_d = (state_d != HOLD) && !fifo_re && !fifo_empty;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= FETCH_LO;
            rd_pending_q <= 1'b0;
            fifo_re      <= 1'b0;
            lo_byte_q    <= '0;
            addr_lo_q    <= '0;
            instr_opcode <= '0;
            instr_arg    <= '0;
            instr_addr   <= '0;
            instr_valid  <= 1'b0;
            illegal      <= 1'b0;
            instr_count  <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            fifo_re      <= fifo_re_d;
            lo_byte_q    <= lo_byte_d;
            addr_lo_q    <= addr_lo_d;
            instr_opcode <= opcode_d;
            instr_arg    <= arg_d;
            instr_addr   <= addr_d;
            instr_valid  <= valid_d;
            illegal      <= illegal_d;
            instr_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of byte streams with hand-decoded
// expectations, plus sequences for stall, flush and mid-word reset.
module tb_instr_fetch;

    localparam int ASZ = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_re;
    logic [7:0]  fifo_r_data = 8'h00;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [3:0]  instr_opcode;
    logic [11:0] instr_arg;
    logic [ASZ-1:0] instr_addr;
    logic        illegal;
    logic [15:0] instr_count;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_re      (fifo_re),
        .fifo_r_data  (fifo_r_data),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_arg    (instr_arg),
        .instr_addr   (instr_addr),
        .illegal      (illegal),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    // FIFO model: bench pushes at wr_ptr, read strobes pop at rd_ptr.
    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Protocol monitors, sampled at the active edge.
    logic prev_re      = 1'b0;
    logic re_empty_err = 1'b0;
    logic re_hold_err  = 1'b0;
    logic re_b2b_err   = 1'b0;

    always @(posedge clk) begin
        prev_re <= fifo_re;
        if (fifo_re) begin
            if (rd_ptr == wr_ptr) begin
                re_empty_err <= 1'b1;
            end else begin
                fifo_r_data <= fifo_mem[rd_ptr];
                rd_ptr      <= rd_ptr + 8'd1;
            end
            if (instr_valid) re_hold_err <= 1'b1;
            if (prev_re)     re_b2b_err  <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_count = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] bytes;   // byte i sent i-th, at bytes[8*i +: 8]
        int          n;
        bit          exp_valid;
        logic [3:0]  op;
        logic [11:0] arg;
        logic [ASZ-1:0] addr;
    } vec_t;

    function automatic vec_t mkv(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3, input int n,
                                 input bit v, input logic [3:0] op, input logic [11:0] arg,
                                 input logic [ASZ-1:0] addr);
        vec_t r;
        r.name = name; r.bytes = {b3, b2, b1, b0}; r.n = n;
        r.exp_valid = v; r.op = op; r.arg = arg; r.addr = addr;
        return r;
    endfunction

    // Push the stream, wait for the outcome and check it; on a decoded word,
    // hold ready low for a few cycles, then transfer (optionally with flush).
    task automatic run_vector(input vec_t v, input bit flush_on_xfer);
        bit seen_valid;
        int ill_cnt;
        for (int i = 0; i < v.n; i++) push(v.bytes[8*i +: 8]);
        seen_valid = 1'b0;
        ill_cnt    = 0;
        for (int i = 0; i < 40 && !seen_valid; i++) begin
            @(negedge clk);
            if (illegal) ill_cnt++;
            if (instr_valid) seen_valid = 1'b1;
        end
        check({v.name, " valid"}, 32'(seen_valid), 32'(v.exp_valid));
        check({v.name, " illegal pulses"}, ill_cnt, v.exp_valid ? 0 : 1);
        if (seen_valid) begin
            for (int c = 0; c < 3; c++) begin
                check({v.name, " opcode"}, 32'(instr_opcode), 32'(v.op));
                check({v.name, " arg"},    32'(instr_arg),    32'(v.arg));
                check({v.name, " addr"},   32'(instr_addr),   32'(v.addr));
                check({v.name, " hold valid"}, 32'(instr_valid), 32'd1);
                @(negedge clk);
            end
            instr_ready = 1'b1;
            flush       = flush_on_xfer;
            @(negedge clk);
            instr_ready = 1'b0;
            flush       = 1'b0;
            if (!flush_on_xfer) exp_count = exp_count + 16'd1;
            check({v.name, " valid after xfer"}, 32'(instr_valid), 32'd0);
            check({v.name, " count"}, 32'(instr_count), 32'(exp_count));
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mkv("compute",   8'h05, 8'h30, 8'h00, 8'h00, 2, 1, 4'h3, 12'h005, 10'h000);
        vecs[1] = mkv("load",      8'h00, 8'h10, 8'hFF, 8'h03, 4, 1, 4'h1, 12'h000, 10'h3FF);
        vecs[2] = mkv("load_oob",  8'h00, 8'h10, 8'h00, 8'h04, 4, 0, 4'h0, 12'h000, 10'h000);
        vecs[3] = mkv("bad_op7",   8'h00, 8'h70, 8'h00, 8'h00, 2, 0, 4'h0, 12'h000, 10'h000);
        vecs[4] = mkv("relu_cfg",  8'h01, 8'h40, 8'h00, 8'h00, 2, 1, 4'h4, 12'h001, 10'h000);
        vecs[5] = mkv("halt",      8'h34, 8'hF2, 8'h00, 8'h00, 2, 1, 4'hF, 12'h234, 10'h000);
        vecs[6] = mkv("store",     8'h78, 8'h26, 8'hAB, 8'h01, 4, 1, 4'h2, 12'h678, 10'h1AB);
        vecs[7] = mkv("nop",       8'h00, 8'h00, 8'h00, 8'h00, 2, 1, 4'h0, 12'h000, 10'h000);
        vecs[8] = mkv("bad_opA",   8'h00, 8'hA0, 8'h00, 8'h00, 2, 0, 4'h0, 12'h000, 10'h000);

        // Reset state while held in reset.
        #1;
        check("rst fifo_re", 32'(fifo_re), 32'd0);
        check("rst valid",   32'(instr_valid), 32'd0);
        check("rst opcode",  32'(instr_opcode), 32'd0);
        check("rst arg",     32'(instr_arg), 32'd0);
        check("rst addr",    32'(instr_addr), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst count",   32'(instr_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Ready while idle must not count anything.
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);
        instr_ready = 1'b0;
        check("idle ready count", 32'(instr_count), 32'd0);
        check("idle ready valid", 32'(instr_valid), 32'd0);

        foreach (vecs[i]) run_vector(vecs[i], 1'b0);

        // FIFO empty after one byte for 10 cycles, then refill.
        push(8'h05);
        repeat (10) @(negedge clk);
        check("stall valid", 32'(instr_valid), 32'd0);
        check("stall fifo_re", 32'(fifo_re), 32'd0);
        run_vector(mkv("stall_done", 8'h30, 8'h00, 8'h00, 8'h00, 1, 1, 4'h3, 12'h005, 10'h000), 1'b0);

        // Flush while waiting for the address high byte.
        push(8'h00); push(8'h10); push(8'hFF);
        repeat (12) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush addr_hi valid", 32'(instr_valid), 32'd0);
        check("flush addr_hi count", 32'(instr_count), 32'(exp_count));
        run_vector(mkv("after_flush", 8'h05, 8'h30, 8'h00, 8'h00, 2, 1, 4'h3, 12'h005, 10'h000), 1'b0);

        // Flush coincident with a transfer: no count increment.
        run_vector(mkv("flush_xfer", 8'h22, 8'h31, 8'h00, 8'h00, 2, 1, 4'h3, 12'h122, 10'h000), 1'b1);
        run_vector(vecs[4], 1'b0);

        // Reset between a low byte and its high byte.
        push(8'h05);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst count", 32'(instr_count), 32'd0);
        check("mid rst valid", 32'(instr_valid), 32'd0);
        check("mid rst fifo_re", 32'(fifo_re), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_count = 16'd0;
        run_vector(vecs[5], 1'b0);

        // Read-strobe protocol over the whole run.
        check("fifo_re while empty", 32'(re_empty_err), 32'd0);
        check("fifo_re during hold", 32'(re_hold_err), 32'd0);
        check("two reads outstanding", 32'(re_b2b_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
